// File: rtl/mac_dot_product_seq.sv
// Sequential dot-product engine: result = sum(a[i]*b[i]) using one iterative shift-add multiplier.
// Latency: done pulses N_PAIRS*(WIDTH+1)+1 cycles after start is accepted, counting the cycle after the accepting edge as the first.
// Backpressure: none queued; start and operand writes are accepted only in IDLE, otherwise dropped.
module mac_dot_product_seq #(
   parameter int WIDTH   = 8,
   parameter int N_PAIRS = 2,
   parameter int OUT_W   = 16,
   localparam int IDX_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_sel_b,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] result,
   output logic             overflow
);

   // Accumulator is wide enough that summing N_PAIRS full products never wraps.
   localparam int ACC_W = 2*WIDTH + $clog2(N_PAIRS) + 1;
   // Extended sum is at least one bit wider than the result so the overflow slice is never empty.
   localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2*WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_ACC,
      S_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_reg [N_PAIRS];
   logic [WIDTH-1:0] b_reg [N_PAIRS];

   logic [PW-1:0]    mcand;
   logic [PW-1:0]    prod;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] bit_cnt;
   logic [IDX_W-1:0] pair;
   logic [IDX_W-1:0] pair_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [EXT_W-1:0] sum_ext;

   logic             start_ok;
   logic             wr_ok;
   logic             idx_ok;
   logic             mul_last;
   logic             pair_last;

   assign mul_last  = (bit_cnt == CNT_W'(WIDTH - 1));
   assign pair_last = (pair == IDX_W'(N_PAIRS - 1));
   assign pair_nxt  = pair + IDX_W'(1);
   assign acc_sum   = acc + ACC_W'(prod);
   assign sum_ext   = EXT_W'(acc_sum);

   // Index compare is done one bit wider so non-power-of-two pair counts reject the unused codes.
   assign idx_ok = ((IDX_W+1)'(wr_idx) < (IDX_W+1)'(N_PAIRS));
   // A start in the same idle cycle takes priority and swallows the write.
   assign wr_ok  = (state_q == S_IDLE) && wr_en && !start && idx_ok;

   // State register; reset aborts any computation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            busy = 1'b1;
            if (mul_last) begin
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            busy    = 1'b1;
            state_d = pair_last ? S_DONE : S_MUL;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operand store, written only while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_PAIRS; i++) begin
            a_reg[i] <= '0;
            b_reg[i] <= '0;
         end
      end else if (wr_ok) begin
         if (wr_sel_b) begin
            b_reg[wr_idx] <= wr_data;
         end else begin
            a_reg[wr_idx] <= wr_data;
         end
      end
   end

   // Shift-add multiplier and accumulator datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand   <= '0;
         mplier  <= '0;
         prod    <= '0;
         bit_cnt <= '0;
         pair    <= '0;
         acc     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  acc     <= '0;
                  pair    <= '0;
                  mcand   <= PW'(a_reg[0]);
                  mplier  <= b_reg[0];
                  prod    <= '0;
                  bit_cnt <= '0;
               end
            end
            S_MUL: begin
               if (mplier[0]) begin
                  prod <= prod + mcand;
               end
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            S_ACC: begin
               acc <= acc_sum;
               if (!pair_last) begin
                  pair    <= pair_nxt;
                  mcand   <= PW'(a_reg[pair_nxt]);
                  mplier  <= b_reg[pair_nxt];
                  prod    <= '0;
                  bit_cnt <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result and overflow are captured once, as the final sum lands, and held through the next run.
   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= '0;
         overflow <= 1'b0;
      end else if ((state_q == S_ACC) && pair_last) begin
         result   <= sum_ext[OUT_W-1:0];
         overflow <= |sum_ext[EXT_W-1:OUT_W];
      end
   end

endmodule
